mi_demux: RTL

MI_DEMUX -- requirements
Module: mi_demux

---
 rtl/mi_pkg.sv | 12 +
 rtl/mi_onehot_chk.sv | 17 +
 rtl/mi_demux.sv | 115 +++++++++++
 3 files changed

// File: rtl/mi_pkg.sv
// Shared types and defaults for the grant-steered demultiplexer.
package mi_pkg;
    localparam int MI_NCH    = 5;
    localparam int MI_DW     = 32;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE   = 2'd1,
        DISCARD = 2'd2
    } mi_state_t;
endpackage

// File: rtl/mi_onehot_chk.sv
// Classifies a grant vector as empty, one-hot or multi-hot (combinational only).
module mi_onehot_chk #(
    parameter int NCH = 5
) (
    input  logic [NCH-1:0] gnt,
    output logic           zero,
    output logic           onehot,
    output logic           multi
);
    logic [NCH-1:0] low_clr;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign low_clr = gnt & (gnt - NCH'(1));
    assign zero    = ~|gnt;
    assign multi   = |low_clr;
    assign onehot  = ~zero & ~multi;
endmodule

// File: rtl/mi_demux.sv
// Routes a source burst to the single granted channel through one shared output
// register; illegal multi-bit grants discard the burst and are counted.
module mi_demux
    import mi_pkg::*;
#(
    parameter int NCH = MI_NCH,
    parameter int DW  = MI_DW
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NCH-1:0]       gnt,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [NCH*DW-1:0]    out_data,
    output logic [NCH-1:0]       out_valid,
    output logic [NCH-1:0]       out_last,
    input  logic [NCH-1:0]       out_ready,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           fsm_state
);
    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a raised valid holds its data until taken.
    mi_state_t      state, state_next;
    logic [NCH-1:0] sel_q;
    logic           valid_q, last_q;
    logic [DW-1:0]  data_q;
    logic           gnt_zero, gnt_onehot, gnt_multi;
    logic           drain, route_load, latch_sel, err_hit;

    mi_onehot_chk #(.NCH(NCH)) u_chk (
        .gnt    (gnt),
        .zero   (gnt_zero),
        .onehot (gnt_onehot),
        .multi  (gnt_multi)
    );

    assign drain = valid_q & (|(out_ready & sel_q));

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        latch_sel  = 1'b0;
        err_hit    = 1'b0;
        route_load = 1'b0;
        case (state)
            IDLE: begin
                if (!gnt_zero) begin
                    if (gnt_onehot) begin
                        latch_sel  = 1'b1;
                        state_next = ROUTE;
                    end else if (gnt_multi) begin
                        err_hit    = 1'b1;
                        state_next = DISCARD;
                    end
                end
            end
            ROUTE: begin
                // A buffered final beat blocks new input until it has left.
                in_ready   = ~(valid_q & last_q) & (~valid_q | drain);
                route_load = in_valid & in_ready;
                if (valid_q & last_q & drain) state_next = IDLE;
            end
            DISCARD: begin
                in_ready = 1'b1;
                if (in_valid & in_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sel_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            if (latch_sel) sel_q <= gnt;
            if (route_load) begin
                valid_q <= 1'b1;
                data_q  <= in_data;
                last_q  <= in_last;
            end else if (drain) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= err_hit;
            if (err_hit && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign out_valid = sel_q & {NCH{valid_q}};
    assign out_last  = sel_q & {NCH{last_q}};
    assign fsm_state = state;

    for (genvar k = 0; k < NCH; k++) begin : g_out
        assign out_data[k*DW +: DW] = sel_q[k] ? data_q : '0;
    end
endmodule
